// File: rtl/rtc_pkg.sv
// Shared constants, FSM states and BCD helpers for the time-of-day counter.
package rtc_pkg;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } rtc_state_e;

  // True when both nibbles are decimal digits and the pair does not exceed max.
  function automatic logic bcd_legal(input logic [7:0] value, input logic [7:0] max);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter wrapping at MAX; carry is high when an increment wraps.
module bcd_pair_counter
  import rtc_pkg::*;
#(
  parameter logic [7:0] MAX       = SEC_MAX,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] r_value;
  logic [7:0] w_next;

  assign value = r_value;
  assign carry = inc && (r_value == MAX);

  // Next BCD value: wrap at MAX, else low digit 9 -> 0 with carry into high digit.
  always_comb begin
    w_next = r_value;
    if (r_value == MAX) begin
      w_next = '0;
    end else if (r_value[3:0] == 4'd9) begin
      w_next = {r_value[7:4] + 4'd1, 4'd0};
    end else begin
      w_next = {r_value[7:4], r_value[3:0] + 4'd1};
    end
  end

  // Value register; a load takes priority over an increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value <= RESET_VAL;
    end else if (load) begin
      r_value <= load_val;
    end else if (inc) begin
      r_value <= w_next;
    end
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// 24-hour BCD time-of-day counter driven by the 1 Hz divider, with a checked
// set-time handshake that resyncs the divider on success.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter logic [23:0] RESET_TIME = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        one_hz,
  input  logic        set_valid,
  input  logic [23:0] set_time,
  output logic        set_ready,
  output logic        set_err,
  output logic        resync,
  output logic [7:0]  hours,
  output logic [7:0]  minutes,
  output logic [7:0]  seconds,
  output logic        day_pulse
);

  rtc_state_e  r_state;
  rtc_state_e  w_state_next;
  logic        r_one_hz_q;
  logic        w_tick;
  logic [23:0] r_set_q;
  logic        r_pend;
  logic        w_pend_next;
  logic        r_set_err;
  logic        r_resync;
  logic        r_day_pulse;
  logic        w_err_next;
  logic        w_resync_next;
  logic        w_accept;
  logic        w_load;
  logic        w_inc;
  logic        w_set_legal;
  logic        w_sec_carry;
  logic        w_min_carry;
  logic        w_hr_carry;

  assign w_tick      = one_hz & ~r_one_hz_q;
  assign w_set_legal = bcd_legal(r_set_q[23:16], HR_MAX) &&
                       bcd_legal(r_set_q[15:8],  MIN_MAX) &&
                       bcd_legal(r_set_q[7:0],   SEC_MAX);

  assign set_err   = r_set_err;
  assign resync    = r_resync;
  assign day_pulse = r_day_pulse;

  // Next-state, handshake and count control. A tick that lands in the accept
  // cycle or in CHECK is parked in pend; a legal set drops it, an illegal set
  // lets it count on the following IDLE cycle.
  always_comb begin
    w_state_next  = r_state;
    set_ready     = 1'b0;
    w_accept      = 1'b0;
    w_load        = 1'b0;
    w_inc         = 1'b0;
    w_pend_next   = r_pend;
    w_err_next    = 1'b0;
    w_resync_next = 1'b0;
    case (r_state)
      IDLE: begin
        set_ready = 1'b1;
        if (set_valid) begin
          w_accept     = 1'b1;
          w_state_next = CHECK;
          w_pend_next  = r_pend | w_tick;
        end else begin
          w_inc       = w_tick | r_pend;
          w_pend_next = 1'b0;
        end
      end
      CHECK: begin
        w_state_next = IDLE;
        if (w_set_legal) begin
          w_load        = 1'b1;
          w_resync_next = 1'b1;
          w_pend_next   = 1'b0;
        end else begin
          w_err_next  = 1'b1;
          w_pend_next = r_pend | w_tick;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Edge detector, request capture, pending tick and output pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_one_hz_q  <= 1'b0;
      r_set_q     <= '0;
      r_pend      <= 1'b0;
      r_set_err   <= 1'b0;
      r_resync    <= 1'b0;
      r_day_pulse <= 1'b0;
    end else begin
      r_one_hz_q  <= one_hz;
      if (w_accept) begin
        r_set_q <= set_time;
      end
      r_pend      <= w_pend_next;
      r_set_err   <= w_err_next;
      r_resync    <= w_resync_next;
      r_day_pulse <= w_hr_carry;
    end
  end

  bcd_pair_counter #(.MAX(SEC_MAX), .RESET_VAL(RESET_TIME[7:0])) u_sec (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_inc),
    .load     (w_load),
    .load_val (r_set_q[7:0]),
    .value    (seconds),
    .carry    (w_sec_carry)
  );

  bcd_pair_counter #(.MAX(MIN_MAX), .RESET_VAL(RESET_TIME[15:8])) u_min (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_sec_carry),
    .load     (w_load),
    .load_val (r_set_q[15:8]),
    .value    (minutes),
    .carry    (w_min_carry)
  );

  bcd_pair_counter #(.MAX(HR_MAX), .RESET_VAL(RESET_TIME[23:16])) u_hr (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_min_carry),
    .load     (w_load),
    .load_val (r_set_q[23:16]),
    .value    (hours),
    .carry    (w_hr_carry)
  );

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper: time kept as seconds-of-day in the model,
// directed scenarios pinned with literals, then randomized sets and ticks.
module tb_rtc_timekeeper;

  localparam logic [23:0] RT = 24'h235958;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        one_hz = 1'b0;
  logic        set_valid = 1'b0;
  logic [23:0] set_time = '0;
  logic        set_ready, set_err, resync, day_pulse;
  logic [7:0]  hours, minutes, seconds;

  rtc_timekeeper #(.RESET_TIME(RT)) dut (
    .clk       (clk),
    .rst       (rst),
    .one_hz    (one_hz),
    .set_valid (set_valid),
    .set_time  (set_time),
    .set_ready (set_ready),
    .set_err   (set_err),
    .resync    (resync),
    .hours     (hours),
    .minutes   (minutes),
    .seconds   (seconds),
    .day_pulse (day_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] b2(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic logic [23:0] to_bcd(input int s);
    return {b2(s / 3600), b2((s / 60) % 60), b2(s % 60)};
  endfunction

  // Returns 1 and the seconds-of-day when t is a legal 24-hour BCD time.
  function automatic bit decode(input logic [23:0] t, output int s);
    int d[6];
    int h, m, x;
    s = 0;
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(t[4*i +: 4]);
      if (d[i] > 9) return 1'b0;
    end
    h = d[5] * 10 + d[4];
    m = d[3] * 10 + d[2];
    x = d[1] * 10 + d[0];
    if (h > 23 || m > 59 || x > 59) return 1'b0;
    s = h * 3600 + m * 60 + x;
    return 1'b1;
  endfunction

  // Reference model
  int          m_secs;
  bit          m_q, m_chk, m_pend;
  logic [23:0] m_setq;
  bit          e_err, e_res, e_day;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      void'(decode(RT, m_secs));
      m_q = 0; m_chk = 0; m_pend = 0; m_setq = '0;
      e_err = 0; e_res = 0; e_day = 0;
    end else begin
      bit tick;
      int s;
      tick = one_hz && !m_q;
      m_q = one_hz;
      e_err = 0; e_res = 0; e_day = 0;
      if (!m_chk) begin
        if (set_valid) begin
          m_setq = set_time;
          m_chk = 1;
          if (tick) m_pend = 1;
        end else if (tick || m_pend) begin
          m_secs = (m_secs + 1) % 86400;
          if (m_secs == 0) e_day = 1;
          m_pend = 0;
        end
      end else begin
        m_chk = 0;
        if (decode(m_setq, s)) begin
          m_secs = s;
          e_res = 1;
          m_pend = 0;
        end else begin
          e_err = 1;
          if (tick) m_pend = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      check("time",      32'({hours, minutes, seconds}), 32'(to_bcd(m_secs)));
      check("set_ready", 32'(set_ready), 32'(!m_chk));
      check("set_err",   32'(set_err),   32'(e_err));
      check("resync",    32'(resync),    32'(e_res));
      check("day_pulse", 32'(day_pulse), 32'(e_day));
    end
  end

  int n_res = 0, n_day = 0, n_err = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (resync)    n_res++;
      if (day_pulse) n_day++;
      if (set_err)   n_err++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hz(input int hold);
    one_hz = 1'b1;
    cyc(hold);
    one_hz = 1'b0;
    cyc(3);
  endtask

  // tick_off: -1 no tick, 0 tick in accept cycle, 1 tick in CHECK cycle.
  task automatic do_set(input logic [23:0] t, input int tick_off);
    int w;
    w = 0;
    set_valid = 1'b1;
    set_time  = t;
    if (tick_off == 0) one_hz = 1'b1;
    while (!set_ready && w < 10) begin
      cyc(1);
      w++;
    end
    check("set_ready_wait", 32'(set_ready), 32'd1);
    cyc(1);
    set_valid = 1'b0;
    if (tick_off == 1) one_hz = 1'b1;
    cyc(1);
    if (tick_off >= 0) begin
      cyc(1);
      one_hz = 1'b0;
    end
    cyc(4);
  endtask

  function automatic logic [31:0] now();
    return 32'({hours, minutes, seconds});
  endfunction

  initial begin
    int h, m, x, s, op;
    logic [23:0] t;

    rst = 1'b0;
    cyc(3);
    check("rst_time",  now(), 32'h235958);
    check("rst_ready", 32'(set_ready), 32'd1);
    check("rst_pulses", 32'({set_err, resync, day_pulse}), 32'd0);
    rst = 1'b1;
    cyc(2);

    hz(1);
    check("lit_235959", now(), 32'h235959);
    hz(1);
    check("lit_000000", now(), 32'h000000);
    check("lit_day_once", 32'(n_day), 32'd1);
    check("lit_no_resync", 32'(n_res), 32'd0);

    do_set(24'h000009, -1);
    check("lit_000009", now(), 32'h000009);
    hz(20);
    check("lit_held_high", now(), 32'h000010);

    do_set(24'h125930, -1);
    check("lit_125930", now(), 32'h125930);
    check("lit_resync2", 32'(n_res), 32'd2);
    check("lit_err0", 32'(n_err), 32'd0);

    do_set(24'h246000, -1);
    do_set(24'h0A0000, -1);
    check("lit_illegal_keep", now(), 32'h125930);
    check("lit_err2", 32'(n_err), 32'd2);
    check("lit_resync_still2", 32'(n_res), 32'd2);

    do_set(24'h010203, 0);
    check("lit_set_overrides_tick", now(), 32'h010203);
    do_set(24'h990000, 0);
    check("lit_illegal_tick_accept", now(), 32'h010204);
    do_set(24'h990000, 1);
    check("lit_illegal_tick_check", now(), 32'h010205);
    do_set(24'h050505, 1);
    check("lit_legal_tick_check", now(), 32'h050505);
    check("lit_resync4", 32'(n_res), 32'd4);

    // Reset while a legal request sits in CHECK.
    set_valid = 1'b1;
    set_time  = 24'h111111;
    cyc(1);
    set_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("async_rst_time",  now(), 32'h235958);
    check("async_rst_ready", 32'(set_ready), 32'd1);
    cyc(2);
    rst = 1'b1;
    cyc(3);
    check("post_rst_time", now(), 32'h235958);
    check("post_rst_no_resync", 32'(n_res), 32'd4);

    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0: cyc(int'($urandom_range(1, 5)));
        1: hz(int'($urandom_range(1, 6)));
        2: begin
          h = int'($urandom_range(0, 23));
          m = int'($urandom_range(0, 59));
          x = int'($urandom_range(0, 59));
          do_set({b2(h), b2(m), b2(x)}, int'($urandom_range(0, 2)) - 1);
        end
        3: begin
          x = int'($urandom_range(55, 59));
          do_set({8'h23, 8'h59, b2(x)}, -1);
        end
        default: begin
          t = 24'($urandom);
          while (decode(t, s)) t = 24'($urandom);
          do_set(t, int'($urandom_range(0, 2)) - 1);
        end
      endcase
    end

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
Time-of-day counter that sits directly downstream of the 1 Hz divider. It consumes the divider's one_hz output and keeps hours, minutes and seconds as packed BCD in 24-hour format. It accepts a set-time request through a valid/ready handshake, rejects illegal BCD values, and on a successful set pulses `resync`. `resync` drives the divider's `trig` input so the new second starts in phase with the set.

Parameters:
RESET_TIME, 24'h000000, packed BCD {hr,min,sec} loaded on reset; must be a legal time.

Ports:
clk  input  1  system clock, same domain as the divider
rst  input  1  asynchronous, active-low reset (asserted when 0)
one_hz  input  1  divider output; only the rising edge is significant
set_valid  input  1  set request
set_time  input  24  requested time, packed BCD {hr[23:16],min[15:8],sec[7:0]}
set_ready  output  1  block can accept a set request
set_err  output  1  one-cycle pulse: last accepted request was illegal
resync  output  1  one-cycle pulse on a successful set; connect to divider trig
hours  output  8  BCD 00..23
minutes  output  8  BCD 00..59
seconds  output  8  BCD 00..59
day_pulse  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover

Behaviour:
- Reset (rst=0, async):
  - {hours,minutes,seconds} = RESET_TIME.
  - FSM = IDLE; set_ready = 1.
  - set_err, resync and day_pulse = 0.
  - one_hz_q = 0; pend = 0.
  - Reset mid-set discards the request.
- Tick detect: one_hz_q registers one_hz each cycle; tick = one_hz & ~one_hz_q. A level held high gives exactly one tick.
- Count, on tick in IDLE (outputs update the cycle after the tick is seen):
  - seconds +1 in BCD.
  - seconds 59 -> 00 carries to minutes; minutes 59 -> 00 carries to hours.
  - hours 23 -> 00 pulses day_pulse in the same cycle the outputs show 00:00:00.
  - The low nibble wraps 9 -> 0 and increments the high nibble.
- FSM states: IDLE, CHECK.
  - IDLE: set_ready = 1. set_valid & set_ready latches set_time into set_q and goes to CHECK.
  - CHECK: set_ready = 0 for exactly one cycle, then always back to IDLE.
  - Legal request means: every nibble <= 9, sec <= 8'h59, min <= 8'h59, hr <= 8'h23.
  - Legal: at the CHECK -> IDLE edge the outputs take set_q, resync = 1 for one cycle, and pend is cleared. Outputs therefore reflect the new time 2 cycles after acceptance.
  - Illegal: set_err = 1 for one cycle and the time is unchanged. If pend = 1, the pending tick is applied in the following cycle, then pend clears.
- Simultaneous events:
  - A tick in the accept cycle or in CHECK sets pend; it does not count immediately.
  - A legal set overrides a pending tick, because resync restarts the second.
  - set_valid during CHECK is ignored; the requester must hold it until set_ready.
- The counter never leaves the legal range; no state is reachable with an illegal nibble.

Decomposition:
- rtc_pkg holds:
  - BCD limit constants: SEC_MAX=8'h59, MIN_MAX=8'h59, HR_MAX=8'h23.
  - FSM state encoding: IDLE, CHECK.
  - A bcd_legal(value, max) function.
- Sub-module bcd_pair_counter (params MAX):
  - Two-digit BCD counter with inc, load and load_val inputs, and value and carry outputs.
  - Instantiated three times; carry of one stage is inc of the next.

Test Plan:
- Reset with RESET_TIME=24'h235958, release rst, two one_hz rising edges -> 23:59:59, then 00:00:00 with day_pulse high for exactly 1 cycle; resync stays 0.
- one_hz held high for 20 cycles from 00:00:09 -> single increment to 00:00:10; nibble carry correct (09 -> 10).
- set_time=24'h125930 with set_valid -> set_ready low 1 cycle; outputs 12:59:30 two cycles after accept; resync 1 cycle; set_err 0.
- set_time=24'h246000 (hour 24) and 24'h0A0000 (non-BCD nibble) -> set_err pulses each time; time unchanged; resync 0.
- Tick in the accept cycle of a legal set to 01:02:03 -> outputs 01:02:03, not 01:02:04. Same tick with an illegal set -> the old time advances by exactly 1 s.
- rst asserted while in CHECK with a legal pending set -> outputs = RESET_TIME immediately (async); no resync after release; set_ready = 1.
